// File: rtl/gray_convert_arbiter.sv
// Arbitrated gray-to-binary converter: grant one requester, convert its word, hold the result until accepted.
// Define GRAY_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module gray_convert_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N-1:0]         gray_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            sel_valid;
    logic [IDW-1:0]  sel_idx;
    logic [N-1:0]    gray_reg;
    logic [IDW-1:0]  id_reg;
    logic [N-1:0]    bin_next;
    logic [N-1:0]    rsp_data_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [N-1:0]    gray_words [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign gray_words[gi] = gray_in[gi*N +: N];
        end
        // Each binary bit is the XOR of all gray bits at or above it.
        for (gi = 0; gi < N; gi++) begin : g_bin
            assign bin_next[gi] = ^gray_reg[N-1:gi];
        end
    endgenerate

`ifdef GRAY_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= IDW'(NREQ - 1);
        end else if (state_reg == IDLE && sel_valid) begin
            ptr_reg <= sel_idx;
        end
    end

    always_comb begin
        int cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_reg) + k) % NREQ;
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = IDW'(cand);
            end
        end
    end
`else
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_valid && req[k]) begin
                sel_valid = 1'b1;
                sel_idx   = IDW'(k);
            end
        end
    end
`endif

    // Grant is forced low while reset is held so it never glitches out during reset.
    always_comb begin
        gnt = '0;
        if (!rst && state_reg == IDLE && sel_valid) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sel_valid) state_next = CONVERT;
            CONVERT: state_next = RESPOND;
            RESPOND: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            gray_reg     <= '0;
            id_reg       <= '0;
            rsp_data_reg <= '0;
            rsp_id_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && sel_valid) begin
                gray_reg <= gray_words[sel_idx];
                id_reg   <= sel_idx;
            end
            if (state_reg == CONVERT) begin
                rsp_data_reg <= bin_next;
                rsp_id_reg   <= id_reg;
            end
        end
    end

    assign rsp_valid = (state_reg == RESPOND);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/gray_convert_arbiter.md
GRAY_CONVERT_ARBITER -- requirements
Module: gray_convert_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, gray/binary word width (legal 2..16).
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (legal 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester conversion request, level, held until granted.
REQ-006 SHALL have port gray_in  input  NREQ*N  packed gray words; requester i at bits [i*N +: N].
REQ-007 SHALL have port gnt  output  NREQ  one-hot grant; the data is accepted on the edge ending a gnt cycle.
REQ-008 SHALL have port rsp_valid  output  1  converted result available.
REQ-009 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-010 SHALL have port rsp_data  output  N  binary value of the granted gray word.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the result when high with rsp_valid.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT and RESPOND; IDLE is the reset state.
REQ-014 In IDLE with req!=0, gnt SHALL decode combinationally to exactly one set bit; otherwise gnt SHALL be 0.
REQ-015 On a grant edge, the FSM SHALL latch the selected gray_in word and index, and SHALL move IDLE->CONVERT.
REQ-016 CONVERT SHALL last exactly one cycle: register b[N-1]=g[N-1], b[i]=b[i+1]^g[i] for i=N-2..0, then move to RESPOND.
REQ-017 rsp_valid SHALL be high throughout RESPOND and SHALL first assert 2 edges after the grant edge.
REQ-018 rsp_valid, rsp_id and rsp_data SHALL remain stable in RESPOND until rsp_ready=1 is sampled.
REQ-019 A handshake (rsp_valid & rsp_ready) SHALL move RESPOND->IDLE; the next gnt is legal no earlier than the following cycle.
REQ-020 rsp_data/rsp_id SHALL hold their last values after a handshake; only rsp_valid drops.
REQ-021 req changes and rsp_ready in IDLE/CONVERT SHALL be ignored; gnt SHALL be 0 outside IDLE.
REQ-022 The arbitration pointer (last granted index) SHALL update only on a grant.
REQ-023 A requester whose own result is pending in RESPOND SHALL NOT be granted until the FSM returns to IDLE.
REQ-024 Throughput SHALL be at most one conversion per 3 cycles (grant, convert, respond) with rsp_ready tied high.

Reset
REQ-025 While rst=1: state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, pointer=NREQ-1, independent of clk.
REQ-026 A reset asserted in CONVERT or RESPOND SHALL drop the pending result with no handshake.
REQ-027 After rst deasserts, the first grant SHALL be possible on the first clk edge.

Configuration
REQ-028 With macro GRAY_ARB_ROUND_ROBIN_EN defined, the search SHALL start at (pointer+1) mod NREQ and grant the first set req bit.
REQ-029 Without GRAY_ARB_ROUND_ROBIN_EN, fixed priority SHALL apply: the lowest set req index wins, and the pointer is unused and need not exist.

Verification
REQ-030 Reset: rst=1 mid-RESPOND -> gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0 immediately; the next single req from 2 is granted to 2.
REQ-031 Single request: req=4'b0100, slot2 gray=4'b0110, rsp_ready=1 -> gnt=4'b0100 at T, rsp_valid at T+2, rsp_id=2, rsp_data=4'b0100.
REQ-032 Contention: req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with macro; 0,0,0,0 without.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESPOND -> rsp_valid/id/data stable, gnt=0, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-034 Arithmetic corners (N=4): gray 0000->0000, 1111->1010, 1000->1111, 0001->0001.
REQ-035 Ignored inputs: rsp_ready=1 in IDLE with req=0 -> no state change; req pulsed during CONVERT -> no gnt until IDLE.
